// File: rtl/array_sum_pkg.sv
// ============================================================================
// Module : array_sum_pkg
// Brief  : Shared defaults, FSM state encoding and length clamp helper for
//          the sequential array summer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package array_sum_pkg;

    localparam int c_n_def   = 10;
    localparam int c_w_def   = 8;
    localparam int c_sw_def  = 16;
    localparam int c_len_w   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Requested lengths beyond the array size collapse onto the full array.
    function automatic logic [c_len_w-1:0] clamp_len(input logic [c_len_w-1:0] len,
                                                     input int n);
        if (int'(len) > n)
            return c_len_w'(n);
        return len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/array_pair_add.sv
// ============================================================================
// Module : array_pair_add
// Brief  : Combinational W-bit pair adder with carry-out (W+1-bit result).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module array_pair_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

`default_nettype wire

// File: rtl/array_sum_seq.sv
// ============================================================================
// Module : array_sum_seq
// Brief  : Time-multiplexed array summer; walks latched operand arrays one
//          element pair per clock through a shared adder. Optional job
//          statistics under macro ARRAY_SUM_SEQ_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module array_sum_seq
    import array_sum_pkg::*;
#(
    parameter int N  = c_n_def,
    parameter int W  = c_w_def,
    parameter int SW = c_sw_def
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    input  logic [c_len_w-1:0]   len,
    input  logic [N*W-1:0]       num1,
    input  logic [N*W-1:0]       num2,
    output logic                 busy,
    output logic                 done,
    output logic [SW-1:0]        sum
`ifdef ARRAY_SUM_SEQ_PERF_EN
    ,
    output logic [15:0]          cycles,
    output logic [15:0]          jobs
`endif
);

    state_t               r_state;
    state_t               w_next_state;
    logic [N*W-1:0]       r_a;
    logic [N*W-1:0]       r_b;
    logic [c_len_w-1:0]   r_len;
    logic [c_len_w-1:0]   r_idx;
    logic [SW-1:0]        r_acc;
    logic [SW-1:0]        r_sum;

    logic [c_len_w-1:0]   w_len_c;
    logic [W-1:0]         w_a_el [N];
    logic [W-1:0]         w_b_el [N];
    logic [W:0]           w_pair;
    logic [SW-1:0]        w_acc_next;
    logic                 w_last;

    assign w_len_c = clamp_len(len, N);

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign w_a_el[i] = r_a[i*W +: W];
        assign w_b_el[i] = r_b[i*W +: W];
    end

    array_pair_add #(.W(W)) u_pair_add (
        .a   (w_a_el[r_idx]),
        .b   (w_b_el[r_idx]),
        .sum (w_pair)
    );

    assign w_acc_next = r_acc + SW'(w_pair);
    assign w_last     = (r_idx == r_len - c_len_w'(1));

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start)
                    w_next_state = (w_len_c == '0) ? ST_DONE : ST_ACCUM;
            end
            ST_ACCUM: begin
                busy = 1'b1;
                if (w_last)
                    w_next_state = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a   <= num1;
                        r_b   <= num2;
                        r_len <= w_len_c;
                        r_acc <= '0;
                        r_idx <= '0;
                        if (w_len_c == '0)
                            r_sum <= '0;
                    end
                end
                ST_ACCUM: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + c_len_w'(1);
                    if (w_last)
                        r_sum <= w_acc_next;
                end
                default: ;
            endcase
        end
    end

    assign sum = r_sum;

`ifdef ARRAY_SUM_SEQ_PERF_EN
    logic [15:0] r_cycles;
    logic [15:0] r_jobs;

    // Cycle count restarts only on an accepted start so it reflects the last job.
    always_ff @(posedge clk) begin
        if (res) begin
            r_cycles <= '0;
            r_jobs   <= '0;
        end else begin
            if (r_state == ST_IDLE && start)
                r_cycles <= '0;
            else if (r_state == ST_ACCUM)
                r_cycles <= r_cycles + 16'd1;
            if (r_state == ST_DONE)
                r_jobs <= r_jobs + 16'd1;
        end
    end

    assign cycles = r_cycles;
    assign jobs   = r_jobs;
`endif

endmodule

`default_nettype wire

// File: tb/tb_array_sum_seq.sv
// ============================================================================
// Module : tb_array_sum_seq
// Brief  : Scoreboard bench for array_sum_seq (checks job statistics too when
//          ARRAY_SUM_SEQ_PERF_EN is defined).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_array_sum_seq;

    localparam int N  = 10;
    localparam int W  = 8;
    localparam int SW = 16;

    logic            clk = 1'b0;
    logic            res;
    logic            start;
    logic [3:0]      len;
    logic [N*W-1:0]  num1;
    logic [N*W-1:0]  num2;
    logic            busy;
    logic            done;
    logic [SW-1:0]   sum;
`ifdef ARRAY_SUM_SEQ_PERF_EN
    logic [15:0]     cycles;
    logic [15:0]     jobs;
`endif

    int n_tests    = 0;
    int n_fail     = 0;
    int done_count = 0;
    int exp_q[$];

    localparam logic [N*W-1:0] c_d1a = {8'd2, 8'd4, 8'd6, 8'd8, 8'd10,
                                        8'd12, 8'd14, 8'd16, 8'd18, 8'd20};
    localparam logic [N*W-1:0] c_d1b = {8'd1, 8'd3, 8'd5, 8'd7, 8'd9,
                                        8'd11, 8'd13, 8'd15, 8'd17, 8'd19};
    localparam logic [N*W-1:0] c_d2a = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1,
                                        8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    localparam logic [N*W-1:0] c_d2b = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5,
                                        8'd6, 8'd7, 8'd8, 8'd9, 8'd10};

    array_sum_seq #(.N(N), .W(W), .SW(SW)) dut (
        .clk    (clk),
        .res    (res),
        .start  (start),
        .len    (len),
        .num1   (num1),
        .num2   (num2),
        .busy   (busy),
        .done   (done),
        .sum    (sum)
`ifdef ARRAY_SUM_SEQ_PERF_EN
        ,
        .cycles (cycles),
        .jobs   (jobs)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pops one expected sum pushed when the job was issued.
    always @(negedge clk) begin
        check("busy_done_excl", {31'd0, busy & done}, 32'd0);
        if (done) begin
            done_count++;
            if (exp_q.size() == 0)
                check("unexpected_done", 32'd1, 32'd0);
            else
                check("sum", {16'd0, sum}, exp_q.pop_front());
        end
    end

    task automatic run_job(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                           input logic [3:0] l, input int exp_sum, input bit scramble);
        int lc;
        int edges;
        int busy_cnt;
        lc       = (int'(l) > N) ? N : int'(l);
        busy_cnt = 0;
        @(negedge clk);
        num1  = a;
        num2  = b;
        len   = l;
        start = 1'b1;
        exp_q.push_back(exp_sum);
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        if (scramble) begin
            num1 = ~a;
            num2 = ~b;
            len  = 4'd1;
        end
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency", edges, lc + 1);
        check("busy_cycles", busy_cnt, lc);
        @(posedge clk);
        #1;
        check("idle_after_done", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int d0;
        int k;
`ifdef ARRAY_SUM_SEQ_PERF_EN
        logic [15:0] jobs0;
`endif
        res   = 1'b1;
        start = 1'b0;
        len   = 4'd0;
        num1  = '0;
        num2  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_sum", {16'd0, sum}, 32'd0);
`ifdef ARRAY_SUM_SEQ_PERF_EN
        check("reset_cycles", {16'd0, cycles}, 32'd0);
        check("reset_jobs", {16'd0, jobs}, 32'd0);
        jobs0 = jobs;
`endif
        res = 1'b0;

        run_job(c_d1a, c_d1b, 4'd10, 210, 1'b0);
`ifdef ARRAY_SUM_SEQ_PERF_EN
        check("perf_cycles", {16'd0, cycles}, 32'd10);
        check("perf_jobs", {16'd0, jobs}, {16'd0, jobs0 + 16'd1});
`endif
        run_job(c_d2a, c_d2b, 4'd10, 85, 1'b1);
        run_job(c_d1a, c_d1b, 4'd3, 105, 1'b0);
        check("sum_held", {16'd0, sum}, 32'd105);
        run_job(c_d1a, c_d1b, 4'd0, 0, 1'b0);
        run_job(c_d1a, c_d1b, 4'd15, 210, 1'b0);

        // Abort at the fifth ACCUM cycle; no done may follow.
        d0 = done_count;
        @(negedge clk);
        num1  = c_d1a;
        num2  = c_d1b;
        len   = 4'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        res = 1'b1;
        @(posedge clk);
        #1;
        res = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'd0);
`ifdef ARRAY_SUM_SEQ_PERF_EN
        check("abort_cycles", {16'd0, cycles}, 32'd0);
`endif
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_done", done_count, d0);
        run_job(c_d1a, c_d1b, 4'd10, 210, 1'b0);

        // start raised while busy and still high in DONE must not spawn jobs.
        d0 = done_count;
        @(negedge clk);
        num1  = c_d1a;
        num2  = c_d1b;
        len   = 4'd3;
        start = 1'b1;
        exp_q.push_back(105);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        len   = 4'd10;
        num1  = {N{8'hFF}};
        k     = 1;
        while (!done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("ignored_start_latency", k, 4);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("single_done", done_count, d0 + 1);
        check("ignored_start_sum", {16'd0, sum}, 32'd105);

        run_job({N{8'hFF}}, {N{8'hFF}}, 4'd10, 5100, 1'b0);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
